// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 16-bit radix-2 multiply/divide with HI/LO result registers
module mul_div_unit #(
    parameter int ITER = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] operand_a,
    input  logic [15:0] operand_b,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [15:0] hi,
    output logic [15:0] lo,
    output logic        div_by_zero
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [1:0]  op_q;
    logic [15:0] b_mag;
    logic [31:0] acc;
    logic [15:0] rem;
    logic        neg_q, neg_r;
    logic        accept, sgn, last, ge;
    logic [15:0] a_mag_in, b_mag_in;
    logic [16:0] mul_sum, shifted;
    logic [31:0] prod_fix;
    logic [15:0] quo_fix, rem_fix;
    assign busy     = state != IDLE;
    assign stall    = (start & ~busy) | busy;
    assign accept   = start & ~busy;
    assign sgn      = op[0];
    assign last     = cnt == 5'(ITER - 1);
    assign a_mag_in = (sgn && operand_a[15]) ? -operand_a : operand_a;
    assign b_mag_in = (sgn && operand_b[15]) ? -operand_b : operand_b;
    // multiply: acc = {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc[31:16]} + (acc[0] ? {1'b0, b_mag} : 17'd0);
    // divide: acc[15:0] shifts dividend bits out and quotient bits in
    assign shifted  = {rem, acc[15]};
    assign ge       = shifted >= {1'b0, b_mag};
    assign prod_fix = neg_q ? -acc : acc;
    assign quo_fix  = neg_q ? -acc[15:0] : acc[15:0];
    assign rem_fix  = neg_r ? -rem : rem;
    always_ff @(posedge clk)
        state <= !rst ? IDLE : state_nxt;
    always_comb
        state_nxt = state == IDLE ? (start ? CALC : IDLE) :
                    state == CALC ? (last ? FIX : CALC) : IDLE;
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt         <= '0;
            op_q        <= '0;
            b_mag       <= '0;
            acc         <= '0;
            rem         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= state == FIX;
            cnt  <= (state == CALC && !last) ? cnt + 5'd1 : 5'd0;
            if (accept) begin
                op_q        <= op;
                b_mag       <= b_mag_in;
                acc         <= {16'd0, a_mag_in};
                rem         <= '0;
                neg_q       <= sgn & (operand_a[15] ^ operand_b[15]);
                neg_r       <= sgn & operand_a[15];
                div_by_zero <= 1'b0;
            end else if (state == CALC) begin
                if (op_q[1]) begin
                    rem       <= ge ? shifted[15:0] - b_mag : shifted[15:0];
                    acc[15:0] <= {acc[14:0], ge};
                end else begin
                    acc <= {mul_sum, acc[15:1]};
                end
            end else if (state == FIX) begin
                // divide by zero leaves rem = |a|, so the sign fix restores raw a
                hi          <= op_q[1] ? rem_fix : prod_fix[31:16];
                lo          <= op_q[1] ? (b_mag == 16'd0 ? 16'hFFFF : quo_fix) : prod_fix[15:0];
                div_by_zero <= op_q[1] && b_mag == 16'd0;
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and random checks of mul_div_unit against an arithmetic scoreboard
module tb_mul_div_unit;
    logic        clk = 0;
    logic        rst = 0;
    logic        start = 0;
    logic [1:0]  op = 0;
    logic [15:0] operand_a = 0;
    logic [15:0] operand_b = 0;
    logic        busy, stall, done, div_by_zero;
    logic [15:0] hi, lo;

    typedef struct {
        logic        dz;
        logic [15:0] hi;
        logic [15:0] lo;
    } res_t;

    res_t exp_q[$];
    int   total = 0;
    int   passed = 0;

    mul_div_unit #(.ITER(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .stall(stall), .done(done),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    function automatic res_t model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        res_t        r;
        int          sa, xb, q, m;
        logic [31:0] p;
        sa = int'($signed(a));
        xb = int'($signed(b));
        r.dz = 1'b0;
        if (!o[1]) begin
            p = o[0] ? 32'(sa * xb) : {16'd0, a} * {16'd0, b};
            r.hi = p[31:16];
            r.lo = p[15:0];
        end else if (b == 16'd0) begin
            r.dz = 1'b1;
            r.hi = a;
            r.lo = 16'hFFFF;
        end else if (!o[0]) begin
            r.lo = a / b;
            r.hi = a % b;
        end else begin
            q = sa / xb;
            m = sa % xb;
            r.lo = q[15:0];
            r.hi = m[15:0];
        end
        return r;
    endfunction

    // called at a falling edge; returns at the falling edge of the done cycle
    task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input bit inject);
        int   n, nb;
        res_t e;
        start = 1; op = o; operand_a = a; operand_b = b;
        exp_q.push_back(model(o, a, b));
        #1 check("stall_at_start", stall, 1);
        @(negedge clk);
        start = 0;
        check("dz_clear_on_accept", div_by_zero, 0);
        n = 0; nb = 0;
        while (!done && n < 40) begin
            if (busy) nb++;
            if (inject && n == 4) begin start = 1; op = 2'b10; operand_a = 16'd9; operand_b = 16'd3; end
            if (inject && n == 5) begin start = 0; op = 2'b11; operand_a = 16'hAAAA; operand_b = 16'h5555; end
            @(negedge clk);
            n++;
        end
        check("busy_cycles", nb, 17);
        check("done_seen", done, 1);
        check("busy_low_with_done", busy, 0);
        e = exp_q.pop_front();
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("div_by_zero", div_by_zero, e.dz);
    endtask

    initial begin
        int dn;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_dz", div_by_zero, 0);
        check("rst_stall", stall, 0);
        rst = 1;
        @(negedge clk);

        do_op(2'b00, 16'd3, 16'd5, 0);
        @(negedge clk);
        check("done_single_pulse", done, 0);

        do_op(2'b01, 16'hFFFE, 16'd3, 0);
        do_op(2'b00, 16'hFFFF, 16'hFFFF, 0);
        @(negedge clk);
        check("done_single_pulse_b2b", done, 0);

        do_op(2'b10, 16'd100, 16'd7, 0);
        do_op(2'b11, 16'hFFF9, 16'd2, 0);
        do_op(2'b11, 16'h8000, 16'hFFFF, 0);
        do_op(2'b01, 16'h8000, 16'h8000, 0);
        do_op(2'b10, 16'h1234, 16'd0, 0);
        do_op(2'b00, 16'd7, 16'd9, 0);
        do_op(2'b11, 16'hFFF0, 16'd0, 0);
        do_op(2'b11, 16'd7, 16'hFFFE, 0);

        do_op(2'b00, 16'd3, 16'd5, 1);
        @(negedge clk);
        check("ignored_start_no_done", done, 0);
        check("ignored_start_idle", busy, 0);

        start = 1; op = 2'b10; operand_a = 16'd100; operand_b = 16'd7;
        @(negedge clk);
        start = 0;
        repeat (7) @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        dn = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("abort_no_done", dn, 0);
        do_op(2'b10, 16'd100, 16'd7, 0);

        for (int i = 0; i < 10; i++)
            do_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
